cache_controller: RTL

//  Sequencing FSM for the set-associative cache_memory array. Sits between the CPU load/store port and main memory.

---
 rtl/cache_controller_if.sv | 62 ++++++
 rtl/cache_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU, cache_memory and main-memory signals of cache_controller
// CACHE_STATS_EN adds the hit_count/miss_count outputs.
interface cache_controller_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2,
  parameter int BLOCK_SIZE = 32
);
  localparam int SET_SIZE = $clog2(NUM_SETS);
  localparam int WAY_SIZE = $clog2(NUM_WAYS);
  localparam int TAG_SIZE = ADDR_SIZE - SET_SIZE - 2;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_SIZE-1:0]  req_addr;
  logic [BLOCK_SIZE-1:0] req_wdata;
  logic                  resp_valid;
  logic [BLOCK_SIZE-1:0] resp_rdata;
  logic [WAY_SIZE-1:0]   way;
  logic [SET_SIZE-1:0]   set;
  logic [TAG_SIZE-1:0]   tag;
  logic                  write_enable;
  logic [BLOCK_SIZE-1:0] write_data;
  logic [BLOCK_SIZE-1:0] read_data;
  logic [NUM_WAYS-1:0]   hits;
  logic [NUM_WAYS-1:0]   valid_flags;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic                  mem_ack;
  logic [BLOCK_SIZE-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
`endif

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output way, set, tag, write_enable, write_data,
    input  read_data, hits, valid_flags,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
`ifdef CACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  way, set, tag, write_enable, write_data,
    output read_data, hits, valid_flags,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
`ifdef CACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - sequencing FSM for a set-associative write-through, no-write-allocate cache
// CACHE_STATS_EN adds load hit/miss counters.
module cache_controller #(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2,
  parameter int BLOCK_SIZE = 32
) (
  input logic clk,
  input logic rst,
  cache_controller_if.master bus
);
  localparam int SET_SIZE = $clog2(NUM_SETS);
  localparam int WAY_SIZE = $clog2(NUM_WAYS);
  localparam int TAG_SIZE = ADDR_SIZE - SET_SIZE - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, FILL, WMEM, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_SIZE-3:0]  word_q;
  logic                  write_q;
  logic [BLOCK_SIZE-1:0] wdata_q;
  logic [BLOCK_SIZE-1:0] rdata_q;
  logic [WAY_SIZE-1:0]   rr_ptr [NUM_SETS];

  logic [SET_SIZE-1:0] set_q;
  logic [TAG_SIZE-1:0] tag_q;
  logic [WAY_SIZE-1:0] hit_way;
  logic [WAY_SIZE-1:0] free_way;
  logic [WAY_SIZE-1:0] victim;
  logic                any_hit;
  logic                any_free;
  logic                unused_addr_bits;

  assign set_q            = word_q[SET_SIZE-1:0];
  assign tag_q            = word_q[ADDR_SIZE-3:SET_SIZE];
  assign unused_addr_bits = ^bus.req_addr[1:0];

  // Descending scan so the lowest-index match is the one left standing.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    any_hit  = 1'b0;
    any_free = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (bus.hits[i]) begin
        hit_way = WAY_SIZE'(i);
        any_hit = 1'b1;
      end
      if (!bus.valid_flags[i]) begin
        free_way = WAY_SIZE'(i);
        any_free = 1'b1;
      end
    end
  end

  assign victim = any_free ? free_way : rr_ptr[set_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = write_q ? WMEM : (any_hit ? RESP : REFILL);
      REFILL:  if (bus.mem_ack) state_nxt = FILL;
      FILL:    state_nxt = RESP;
      WMEM:    if (bus.mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        word_q  <= bus.req_addr[ADDR_SIZE-1:2];
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state == LOOKUP && !write_q && any_hit) rdata_q <= bus.read_data;
      if (state == REFILL && bus.mem_ack)        rdata_q <= bus.mem_rdata;
    end
  end

  // Round-robin advances only when every way was valid and the pointer chose the victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (state == FILL && !any_free) begin
      rr_ptr[set_q] <= rr_ptr[set_q] + 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else if (state == LOOKUP && !write_q) begin
      if (any_hit) bus.hit_count  <= bus.hit_count + 32'd1;
      else         bus.miss_count <= bus.miss_count + 32'd1;
    end
  end
`endif

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = '0;
    bus.way          = '0;
    bus.set          = '0;
    bus.tag          = '0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (state != IDLE) begin
      bus.set = set_q;
      bus.tag = tag_q;
    end
    case (state)
      LOOKUP: if (write_q && any_hit) begin
        bus.write_enable = 1'b1;
        bus.way          = hit_way;
        bus.write_data   = wdata_q;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {word_q, 2'b00};
      end
      FILL: begin
        bus.write_enable = 1'b1;
        bus.way          = victim;
        bus.write_data   = rdata_q;
        bus.resp_rdata   = rdata_q;
      end
      WMEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {word_q, 2'b00};
        bus.mem_wdata = wdata_q;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end
endmodule
